// File: rtl/branch_redirect_unit_pkg.sv
// branch_redirect_unit_pkg: FSM state encodings, default reset PC and PC increment helper.
package branch_redirect_unit_pkg;

    typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/branch_redirect_unit_flopenrc.sv
// branch_redirect_unit_flopenrc: pipeline register with enable and synchronous clear.
module branch_redirect_unit_flopenrc #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear wins over enable so a flush also kills a stalled stage.
    always_ff @(posedge clk) begin
        if (rst || clr) q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/branch_redirect_unit.sv
// branch_redirect_unit: fetch PC sequencer and branch-mispredict recovery controller.
// Optional performance counters are built when BRU_PERF_CNT_EN is defined.
module branch_redirect_unit
    import branch_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallF,
    input  logic             stallD,
    input  logic             flushE_in,
    input  logic             branchD,
    input  logic             pred_takeD,
    input  logic [31:0]      branch_targetD,
    input  logic             branchM,
    input  logic             actual_takeM,
    input  logic             correct,
    output logic [31:0]      pcF,
    output logic [31:0]      pcD,
    output logic [31:0]      pcM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic             mispredM,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    state_t      state, state_next;
    logic [31:0] pend_pc, pc_next, recoverD, pcE, recoverE, recoverM;
    logic        redirect_d, unused_ok;

    assign unused_ok  = ^{branchD, actual_takeM};
    assign mispredM   = branchM & ~correct;
    assign redirect_d = pred_takeD & ~stallD;
    assign flushD     = mispredM | redirect_d;
    assign flushE     = flushE_in | mispredM;
    assign flushM     = mispredM;
    assign recoverD   = pred_takeD ? pc_inc(pcD) : branch_targetD;

    // A redirect that cannot load because F is stalled is parked in PEND.
    always_comb begin
        state_next = ((mispredM || state == PEND) && stallF) ? PEND : RUN;
        pc_next    = mispredM ? recoverM : (state == PEND) ? pend_pc : redirect_d ? branch_targetD : pc_inc(pcF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            pcF     <= RESET_PC;
            pend_pc <= '0;
        end else begin
            state <= state_next;
            if (!stallF) pcF <= pc_next;
            if (mispredM && stallF) pend_pc <= recoverM;
        end
    end

    branch_redirect_unit_flopenrc #(.W(32)) u_reg_d (
        .clk(clk), .rst(rst), .en(~stallD), .clr(flushD),
        .d(pcF), .q(pcD)
    );

    branch_redirect_unit_flopenrc #(.W(64)) u_reg_e (
        .clk(clk), .rst(rst), .en(1'b1), .clr(flushE),
        .d({pcD, recoverD}), .q({pcE, recoverE})
    );

    branch_redirect_unit_flopenrc #(.W(64)) u_reg_m (
        .clk(clk), .rst(rst), .en(1'b1), .clr(flushM),
        .d({pcE, recoverE}), .q({pcM, recoverM})
    );

`ifdef BRU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (branchM && !(&branch_cnt)) branch_cnt <= branch_cnt + CNT_W'(1);
            if (mispredM && !(&mispred_cnt)) mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
    end
`else
    assign branch_cnt  = '0;
    assign mispred_cnt = '0;
`endif

endmodule
